// File: rtl/proc_pkg.sv
// Shared definitions for the instruction issuer: opcodes, field positions,
// FIFO geometry, timeout length and the issue FSM state type.
package proc_pkg;

  localparam int INSTR_W    = 16;
  localparam int RETIRED_W  = 16;

  // Instruction word: III M XXX DDDDDDDDD
  localparam int OP_MSB     = 15;
  localparam int OP_LSB     = 13;
  localparam int M_BIT      = 12;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVT = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  localparam int FIFO_DEPTH     = 8;
  localparam int PTR_W          = 3;
  localparam int COUNT_W        = 4;

  localparam int TIMEOUT_CYCLES = 8;
  localparam int WAIT_CNT_W     = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  // Opcodes outside the four supported ones, or mvt without its M bit.
  function automatic logic is_illegal(input logic [INSTR_W-1:0] w);
    logic [2:0] op;
    op = w[OP_MSB:OP_LSB];
    return !(op inside {OP_MV, OP_MVT, OP_ADD, OP_SUB}) ||
           ((op == OP_MVT) && !w[M_BIT]);
  endfunction

endpackage

// File: rtl/instr_issuer_if.sv
// Host/processor-facing signal bundle of the instruction issuer.
// slave: the issuer side; master: the host/processor side driving it.
interface instr_issuer_if
  import proc_pkg::*;
;
  logic                 WrEn;
  logic [INSTR_W-1:0]   WrData;
  logic                 Start;
  logic                 Done;
  logic [INSTR_W-1:0]   DIN;
  logic                 Run;
  logic                 Full;
  logic                 Empty;
  logic [COUNT_W-1:0]   Count;
  logic                 Busy;
  logic [RETIRED_W-1:0] Retired;
  logic                 Timeout;
  logic                 Dropped;

  modport slave (
    input  WrEn, WrData, Start, Done,
    output DIN, Run, Full, Empty, Count, Busy, Retired, Timeout, Dropped
  );

  modport master (
    output WrEn, WrData, Start, Done,
    input  DIN, Run, Full, Empty, Count, Busy, Retired, Timeout, Dropped
  );

endinterface

// File: rtl/instr_fifo.sv
// 8 x 16 instruction FIFO; pointers and occupancy cleared by synchronous
// active-low reset, storage left uninitialised. Head word is read combinationally.
module instr_fifo
  import proc_pkg::*;
(
  input  logic               Clock,
  input  logic               Resetn,
  input  logic               push,
  input  logic               pop,
  input  logic [INSTR_W-1:0] wr_data,
  output logic [INSTR_W-1:0] rd_data,
  output logic [COUNT_W-1:0] count,
  output logic               full,
  output logic               empty
);

  logic [INSTR_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               do_push, do_pop;

  assign full    = (count_q == COUNT_W'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Full blocks a push even if a pop frees a slot in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + COUNT_W'(do_push) - COUNT_W'(do_pop);
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge Clock) begin
    if (Resetn && do_push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/instr_issuer.sv
// Issues queued instruction words to the processor one at a time (Run/Done
// handshake) with a WAIT timeout. ILLEGAL_OP_FILTER_EN enables write-side opcode filtering.
module instr_issuer
  import proc_pkg::*;
(
  input  logic          Clock,
  input  logic          Resetn,
  instr_issuer_if.slave bus
);

  state_e                 state_q, state_d;
  logic [WAIT_CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [RETIRED_W-1:0]   retired_q, retired_d;
  logic                   timeout_q, timeout_d;
  logic                   run_q, run_d;
  logic                   busy_q, busy_d;

  logic                   illegal;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic [COUNT_W-1:0]     fifo_count;
  logic [INSTR_W-1:0]     fifo_head;

`ifdef ILLEGAL_OP_FILTER_EN
  logic dropped_q, dropped_d;

  assign illegal     = is_illegal(bus.WrData);
  assign dropped_d   = bus.WrEn && illegal;
  assign bus.Dropped = dropped_q;

  always_ff @(posedge Clock) begin
    if (!Resetn) dropped_q <= 1'b0;
    else         dropped_q <= dropped_d;
  end
`else
  assign illegal     = 1'b0;
  assign bus.Dropped = 1'b0;
`endif

  assign fifo_push = bus.WrEn && !illegal;
  // The issued word leaves the FIFO on the ISSUE->WAIT edge.
  assign fifo_pop  = (state_q == ST_ISSUE);

  instr_fifo u_fifo (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (bus.WrData),
    .rd_data (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    retired_d  = retired_q;
    timeout_d  = timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.Start && !fifo_empty && !timeout_q) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        state_d    = ST_WAIT;
        wait_cnt_d = '0;
      end
      ST_WAIT: begin
        // fifo_empty already reflects the pop of the in-flight word.
        if (bus.Done) begin
          retired_d = retired_q + RETIRED_W'(1);
          state_d   = (bus.Start && !fifo_empty) ? ST_ISSUE : ST_IDLE;
        end else if (wait_cnt_q == WAIT_CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    run_d  = (state_d == ST_ISSUE);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      retired_q  <= '0;
      timeout_q  <= 1'b0;
      run_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      retired_q  <= retired_d;
      timeout_q  <= timeout_d;
      run_q      <= run_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.DIN     = fifo_head;
  assign bus.Run     = run_q;
  assign bus.Full    = fifo_full;
  assign bus.Empty   = fifo_empty;
  assign bus.Count   = fifo_count;
  assign bus.Busy    = busy_q;
  assign bus.Retired = retired_q;
  assign bus.Timeout = timeout_q;

endmodule

// File: tb/tb_instr_issuer.sv
// Bench for instr_issuer: directed scenarios plus randomized traffic, all
// checked every cycle against a queue-based reference model and a processor model.
module tb_instr_issuer;

  logic Clock = 1'b0;
  logic Resetn;

  instr_issuer_if bus ();

  instr_issuer dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus.slave)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: queue contents, an "instruction presented" flag, an
  // "instruction in flight" flag with elapsed wait cycles, and counters.
  logic [15:0] m_q[$];
  logic [15:0] m_retired;
  bit          m_timeout, m_present, m_await, m_dropped;
  int          m_waited;

  // Processor model driving Done.
  bit p_busy, rand_mode, hang_next;
  int p_left;

  function automatic bit filtered(input logic [15:0] w);
`ifdef ILLEGAL_OP_FILTER_EN
    return ((w >> 13) >= 16'd4) || ((w >> 12) == 16'd2);
`else
    return (w == 16'd0) && (w != 16'd0);
`endif
  endfunction

  function automatic int latency(input logic [15:0] w);
    int op;
    op = int'(w >> 13);
    return (op == 2 || op == 3) ? 3 : 1;
  endfunction

  task automatic model_step();
    int sz;
    bit was_present, was_await, wr;
    sz          = m_q.size();
    was_present = m_present;
    was_await   = m_await;
    if (!Resetn) begin
      m_q.delete();
      m_retired = '0;
      m_timeout = 0;
      m_present = 0;
      m_await   = 0;
      m_dropped = 0;
      p_busy    = 0;
      return;
    end
    m_dropped = bus.WrEn && filtered(bus.WrData);
    wr        = bus.WrEn && !filtered(bus.WrData) && (sz < 8);
    if (was_present) begin
      m_present = 0;
      m_await   = 1;
      m_waited  = 0;
    end else if (was_await) begin
      if (bus.Done) begin
        m_retired = m_retired + 16'd1;
        m_await   = 0;
        m_present = bus.Start && (sz > 0);
      end else begin
        m_waited++;
        if (m_waited == 8) begin
          m_timeout = 1;
          m_await   = 0;
        end
      end
    end else begin
      m_present = bus.Start && (sz > 0) && !m_timeout;
    end
    if (was_present) void'(m_q.pop_front());
    if (wr) m_q.push_back(bus.WrData);
  endtask

  task automatic compare();
    check_eq("count",   32'(bus.Count),   32'(m_q.size()));
    check_eq("empty",   32'(bus.Empty),   32'(m_q.size() == 0));
    check_eq("full",    32'(bus.Full),    32'(m_q.size() == 8));
    check_eq("run",     32'(bus.Run),     32'(m_present));
    check_eq("busy",    32'(bus.Busy),    32'(m_present || m_await));
    check_eq("retired", 32'(bus.Retired), 32'(m_retired));
    check_eq("timeout", 32'(bus.Timeout), 32'(m_timeout));
    check_eq("dropped", 32'(bus.Dropped), 32'(m_dropped));
    if (m_present && m_q.size() > 0) check_eq("din", 32'(bus.DIN), 32'(m_q[0]));
  endtask

  task automatic processor_step();
    if (bus.Run === 1'b1) begin
      p_busy    = 1;
      p_left    = hang_next ? 12 : latency(bus.DIN) + (rand_mode ? int'($urandom_range(0, 2)) : 0);
      hang_next = 0;
      bus.Done  = rand_mode && ($urandom_range(0, 3) == 0);
    end else if (p_busy) begin
      p_left--;
      bus.Done = (p_left == 0);
      if (p_left == 0) p_busy = 0;
    end else begin
      bus.Done = rand_mode && ($urandom_range(0, 5) == 0);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    model_step();
    @(negedge Clock);
    compare();
    processor_step();
  endtask

  task automatic do_reset();
    Resetn    = 1'b0;
    bus.WrEn  = 1'b0;
    bus.Start = 1'b0;
    hang_next = 0;
    tick();
    Resetn = 1'b1;
  endtask

  task automatic write_word(input logic [15:0] w);
    bus.WrEn   = 1'b1;
    bus.WrData = w;
    tick();
    bus.WrEn   = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int runs, gap, first, got, waits, drops;
    bit seen;
    logic [15:0] din, words[9], got_words[8];

    Resetn     = 1'b0;
    bus.WrEn   = 1'b0;
    bus.WrData = '0;
    bus.Start  = 1'b0;
    bus.Done   = 1'b0;
    p_busy = 0; rand_mode = 0; hang_next = 0; p_left = 0;
    m_retired = '0; m_timeout = 0; m_present = 0; m_await = 0; m_dropped = 0; m_waited = 0;

    // Reset state, then a single mv issued and retired.
    do_reset();
    check_eq("rst_empty",   32'(bus.Empty),   32'd1);
    check_eq("rst_count",   32'(bus.Count),   32'd0);
    check_eq("rst_busy",    32'(bus.Busy),    32'd0);
    check_eq("rst_retired", 32'(bus.Retired), 32'd0);
    bus.Start = 1'b1;
    write_word(16'h1205);
    runs = 0; din = '0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.Run === 1'b1) begin runs++; din = bus.DIN; end
    end
    check_eq("t1_runs",    32'(runs),        32'd1);
    check_eq("t1_din",     32'(din),         32'h1205);
    check_eq("t1_retired", 32'(bus.Retired), 32'd1);

    // add then sub: Run pulses 4 cycles apart.
    do_reset();
    write_word(16'h4001);
    write_word(16'h7001);
    bus.Start = 1'b1;
    runs = 0; first = 0; gap = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.Run === 1'b1) begin
        if (runs == 0) first = i; else gap = i - first;
        runs++;
      end
    end
    check_eq("t2_runs",    32'(runs),        32'd2);
    check_eq("t2_gap",     32'(gap),         32'd4);
    check_eq("t2_retired", 32'(bus.Retired), 32'd2);
    check_eq("t2_empty",   32'(bus.Empty),   32'd1);

    // Nine writes with Start low: only the first eight are kept, in order.
    do_reset();
    for (int i = 0; i < 9; i++) words[i] = {3'b000, 13'($urandom)};
    for (int i = 0; i < 9; i++) write_word(words[i]);
    check_eq("t3_count", 32'(bus.Count), 32'd8);
    check_eq("t3_full",  32'(bus.Full),  32'd1);
    bus.Start = 1'b1;
    got = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (bus.Run === 1'b1) begin
        if (got < 8) got_words[got] = bus.DIN;
        got++;
      end
    end
    check_eq("t3_drained", 32'(got), 32'd8);
    for (int i = 0; i < 8; i++) check_eq($sformatf("t3_word%0d", i), 32'(got_words[i]), 32'(words[i]));
    check_eq("t3_empty", 32'(bus.Empty), 32'd1);

    // Missing Done: timeout after 8 WAIT cycles, then no further issue.
    do_reset();
    write_word(16'h1001);
    write_word(16'h1002);
    hang_next = 1;
    bus.Start = 1'b1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (bus.Run === 1'b1) seen = 1;
    end
    check_eq("t4_run_seen", 32'(seen), 32'd1);
    waits = 0;
    for (int i = 0; i < 20 && bus.Timeout !== 1'b1; i++) begin
      tick();
      if (bus.Busy === 1'b1) waits++;
    end
    check_eq("t4_wait_cycles", 32'(waits),       32'd8);
    check_eq("t4_timeout",     32'(bus.Timeout), 32'd1);
    check_eq("t4_busy",        32'(bus.Busy),    32'd0);
    runs = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.Run === 1'b1) runs++;
    end
    check_eq("t4_no_run", 32'(runs),      32'd0);
    check_eq("t4_count",  32'(bus.Count), 32'd1);

    // Illegal opcode and mvt without M.
    do_reset();
    drops = 0;
    bus.WrEn = 1'b1; bus.WrData = 16'h8000; tick(); drops += int'(bus.Dropped);
    bus.WrData = 16'h2005;                  tick(); drops += int'(bus.Dropped);
    bus.WrEn = 1'b0;                        tick(); drops += int'(bus.Dropped);
`ifdef ILLEGAL_OP_FILTER_EN
    check_eq("t5_drops", 32'(drops),     32'd2);
    check_eq("t5_count", 32'(bus.Count), 32'd0);
`else
    check_eq("t5_drops", 32'(drops),     32'd0);
    check_eq("t5_count", 32'(bus.Count), 32'd2);
`endif

    // Reset while an instruction is in flight, with Done raised in that cycle.
    do_reset();
    write_word(16'h4001);
    write_word(16'h1205);
    bus.Start = 1'b1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (bus.Run === 1'b1) seen = 1;
    end
    tick();
    check_eq("t6_busy", 32'(bus.Busy), 32'd1);
    Resetn   = 1'b0;
    bus.Done = 1'b1;
    tick();
    Resetn = 1'b1;
    check_eq("t6_run",     32'(bus.Run),     32'd0);
    check_eq("t6_count",   32'(bus.Count),   32'd0);
    check_eq("t6_retired", 32'(bus.Retired), 32'd0);

    // Randomized traffic with spurious Done, variable latency, hangs and resets.
    do_reset();
    rand_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      Resetn     = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
      bus.WrEn   = ($urandom_range(0, 2) == 0);
      bus.WrData = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                               : {3'($urandom_range(0, 3)), 13'($urandom)};
      bus.Start  = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 39) == 0) hang_next = 1;
      tick();
    end
    Resetn = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
